// File: rtl/eth_pkg.sv
// Shared Ethernet constants, rx_status bit positions and the RX frame FSM encoding.
`timescale 1ns/1ps
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam logic [47:0] ETH_BCAST     = 48'hFFFF_FFFF_FFFF;

  localparam int ST_CRC_ERR   = 0;
  localparam int ST_GMII_ERR  = 1;
  localparam int ST_RUNT      = 2;
  localparam int ST_OVERSIZE  = 3;
  localparam int ST_ADDR_MISS = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide next-state function of the reflected Ethernet CRC-32.
`timescale 1ns/1ps
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive frame engine: strips preamble/SFD, delivers DA..payload without FCS
// and reports CRC, length, GMII-error and address status per frame.
`timescale 1ns/1ps
module gmii_rx_frame_checker
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h000A35010203,
  parameter logic        PROMISC  = 1'b0,
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [4:0]  rx_status,
  output logic        rx_good,
  output logic [15:0] rx_frame_len,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt
);

  localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  rx_state_e       state_q, state_d;
  logic            armed_q, armed_d;
  logic [4:0][7:0] dly_q, dly_d;
  logic [15:0]     len_q, len_d;
  logic [31:0]     crc_q, crc_d, crc_next;
  logic [47:0]     da_q, da_d;
  logic            gerr_q, gerr_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_sof_q, rx_sof_d;
  logic            rx_eof_q, rx_eof_d;
  logic [4:0]      rx_status_q, rx_status_d;
  logic            rx_good_q, rx_good_d;
  logic [15:0]     rx_frame_len_q, rx_frame_len_d;
  logic [31:0]     good_cnt_q, good_cnt_d;
  logic [31:0]     bad_cnt_q, bad_cnt_d;
  logic [4:0]      status_now;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .d       (gmii_rxd),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Until the line has been seen idle once, IDLE ignores dv so a frame cut by reset is never picked up mid-way.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (armed_q && gmii_rx_dv)
                state_d = (gmii_rxd == ETH_PREAMBLE && !gmii_rx_er) ? S_PRE : S_DROP;
      S_PRE:  if (!gmii_rx_dv)                state_d = S_IDLE;
              else if (gmii_rx_er)            state_d = S_DROP;
              else if (gmii_rxd == ETH_SFD)   state_d = S_DATA;
              else if (gmii_rxd != ETH_PREAMBLE) state_d = S_DROP;
      S_DATA: if (!gmii_rx_dv) state_d = S_IDLE;
      S_DROP: if (!gmii_rx_dv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status_now               = '0;
    status_now[ST_CRC_ERR]   = (crc_q != CRC32_RESIDUE);
    status_now[ST_GMII_ERR]  = gerr_q;
    status_now[ST_RUNT]      = (len_q < MIN_LEN16);
    status_now[ST_OVERSIZE]  = (len_q > MAX_LEN16);
    status_now[ST_ADDR_MISS] = !PROMISC && (da_q != MAC_ADDR) && (da_q != ETH_BCAST) && !da_q[40];
  end

  always_comb begin
    armed_d        = armed_q | ~gmii_rx_dv;
    dly_d          = dly_q;
    len_d          = len_q;
    crc_d          = crc_q;
    da_d           = da_q;
    gerr_d         = gerr_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_sof_d       = 1'b0;
    rx_eof_d       = 1'b0;
    rx_good_d      = 1'b0;
    rx_status_d    = rx_status_q;
    rx_frame_len_d = rx_frame_len_q;
    good_cnt_d     = good_cnt_q;
    bad_cnt_d      = bad_cnt_q;

    if (state_q == S_PRE && state_d == S_DATA) begin
      len_d  = '0;
      crc_d  = 32'hFFFF_FFFF;
      da_d   = '0;
      gerr_d = 1'b0;
    end

    if (state_d == S_DROP && state_q != S_DROP) bad_cnt_d = bad_cnt_q + 32'd1;

    // The 5-deep delay line hides the trailing 4 FCS bytes: whatever is still inside at EOF is FCS.
    if (state_q == S_DATA) begin
      if (gmii_rx_dv) begin
        dly_d = {dly_q[3:0], gmii_rxd};
        crc_d = crc_next;
        len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
        if (len_q < 16'd6) da_d = {da_q[39:0], gmii_rxd};
        if (gmii_rx_er)    gerr_d = 1'b1;
        if (len_q >= 16'd5) begin
          rx_valid_d = 1'b1;
          rx_data_d  = dly_q[4];
          rx_sof_d   = (len_q == 16'd5);
        end
      end else if (len_q >= 16'd5) begin
        rx_valid_d     = 1'b1;
        rx_data_d      = dly_q[4];
        rx_sof_d       = (len_q == 16'd5);
        rx_eof_d       = 1'b1;
        rx_status_d    = status_now;
        rx_frame_len_d = len_q;
        rx_good_d      = (status_now == 5'd0);
        if (status_now == 5'd0) good_cnt_d = good_cnt_q + 32'd1;
        else                    bad_cnt_d  = bad_cnt_q + 32'd1;
      end else begin
        bad_cnt_d = bad_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q        <= 1'b0;
      dly_q          <= '0;
      len_q          <= '0;
      crc_q          <= 32'hFFFF_FFFF;
      da_q           <= '0;
      gerr_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_sof_q       <= 1'b0;
      rx_eof_q       <= 1'b0;
      rx_status_q    <= '0;
      rx_good_q      <= 1'b0;
      rx_frame_len_q <= '0;
      good_cnt_q     <= '0;
      bad_cnt_q      <= '0;
    end else begin
      armed_q        <= armed_d;
      dly_q          <= dly_d;
      len_q          <= len_d;
      crc_q          <= crc_d;
      da_q           <= da_d;
      gerr_q         <= gerr_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_sof_q       <= rx_sof_d;
      rx_eof_q       <= rx_eof_d;
      rx_status_q    <= rx_status_d;
      rx_good_q      <= rx_good_d;
      rx_frame_len_q <= rx_frame_len_d;
      good_cnt_q     <= good_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_sof       = rx_sof_q;
  assign rx_eof       = rx_eof_q;
  assign rx_status    = rx_status_q;
  assign rx_good      = rx_good_q;
  assign rx_frame_len = rx_frame_len_q;
  assign good_cnt     = good_cnt_q;
  assign bad_cnt      = bad_cnt_q;

endmodule
